// File: rtl/led_frame_scheduler.sv
// Frame sequencer for a serpentine WS2812B matrix: walks the LED chain, fetches
// each pixel from the frame buffer, scales it by a global brightness and hands it to the serializer.
module led_frame_scheduler #(
  parameter int MATRIX_W     = 5,
  parameter int MATRIX_H     = 5,
  parameter int LATCH_CYCLES = 2700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  brightness,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  led_idx,
  output logic [3:0]  pix_x,
  output logic [3:0]  pix_y,
  output logic        pix_rd,
  input  logic [23:0] pix_data,
  output logic [23:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        tx_idle
);

  localparam int              NUM_LEDS   = MATRIX_W * MATRIX_H;
  localparam int              LCW        = $clog2(LATCH_CYCLES + 1);
  localparam logic [7:0]      LAST_IDX   = 8'(NUM_LEDS - 1);
  localparam logic [3:0]      COL_MAX    = 4'(MATRIX_W - 1);
  localparam logic [LCW-1:0]  LATCH_LOAD = LCW'(LATCH_CYCLES - 1);
  localparam logic [LCW-1:0]  LATCH_ONE  = LCW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_DRAIN,
    S_LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       bright_q, bright_d;
  logic [7:0]       led_idx_q, led_idx_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       x_q, x_d;
  logic             dir_q, dir_d;
  logic [23:0]      tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [LCW-1:0]   latch_cnt_q, latch_cnt_d;
  logic             frame_done_q, frame_done_d;

  logic [23:0]      scaled;
  logic [8:0]       bright_plus1;

  assign bright_plus1 = {1'b0, bright_q} + 9'd1;

  // (c * (brightness + 1)) >> 8 per channel; brightness 255 is an exact pass-through.
  for (genvar gi = 0; gi < 3; gi++) begin : g_scale
    logic [16:0] prod;
    assign prod = {9'd0, pix_data[gi*8 +: 8]} * {8'd0, bright_plus1};
    assign scaled[gi*8 +: 8] = 8'(prod >> 8);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bright_q     <= '0;
      led_idx_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      x_q          <= '0;
      dir_q        <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      latch_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bright_q     <= bright_d;
      led_idx_q    <= led_idx_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_q          <= x_d;
      dir_q        <= dir_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      latch_cnt_q  <= latch_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bright_d     = bright_q;
    led_idx_d    = led_idx_q;
    col_d        = col_q;
    row_d        = row_q;
    x_d          = x_q;
    dir_d        = dir_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    latch_cnt_d  = latch_cnt_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bright_d  = brightness;
          led_idx_d = '0;
          col_d     = '0;
          row_d     = '0;
          x_d       = '0;
          dir_d     = 1'b0;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        tx_data_d  = scaled;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end

      S_SEND: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (led_idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end else begin
            led_idx_d = led_idx_q + 8'd1;
            state_d   = S_FETCH;
            // At a row wrap x stays put: the serpentine turns back on the same column.
            if (col_q == COL_MAX) begin
              col_d = '0;
              row_d = row_q + 4'd1;
              dir_d = ~dir_q;
            end else begin
              col_d = col_q + 4'd1;
              x_d   = dir_q ? (x_q - 4'd1) : (x_q + 4'd1);
            end
          end
        end
      end

      S_DRAIN: begin
        if (tx_idle) begin
          latch_cnt_d = LATCH_LOAD;
          state_d     = S_LATCH;
        end
      end

      S_LATCH: begin
        if (latch_cnt_q == '0) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q - LATCH_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign pix_rd     = (state_q == S_FETCH);
  assign frame_done = frame_done_q;
  assign led_idx    = led_idx_q;
  assign pix_x      = x_q;
  assign pix_y      = row_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler: scoreboard of expected words per frame,
// table of scaling vectors, and hand-written start/reset/drain sequences.
module tb_led_frame_scheduler;

  localparam int W = 5;
  localparam int H = 5;
  localparam int N = W * H;
  localparam int L = 2700;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  brightness;
  logic        busy;
  logic        frame_done;
  logic [7:0]  led_idx;
  logic [3:0]  pix_x;
  logic [3:0]  pix_y;
  logic        pix_rd;
  logic [23:0] pix_data;
  logic [23:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_idle;

  led_frame_scheduler #(.MATRIX_W(W), .MATRIX_H(H), .LATCH_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .start(start), .brightness(brightness),
    .busy(busy), .frame_done(frame_done), .led_idx(led_idx),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rd(pix_rd), .pix_data(pix_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  idx;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [23:0] data;
  } exp_t;

  typedef struct packed {
    logic [7:0]  bright;
    logic [23:0] pix;
    logic [23:0] exp;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          xfer_base = 0;
  int          last_xfer_cyc = 0;
  int          done_cnt = 0;
  bit          mon_en = 1'b0;
  bit          bp_mode = 1'b0;
  int          fb_mode = 0;
  logic [23:0] fb_const = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] fb_word(input logic [3:0] x, input logic [3:0] y);
    case (fb_mode)
      0:       return {16'h0000, x, y};
      1:       return {x, y, 8'h5A, ~x, ~y};
      default: return fb_const;
    endcase
  endfunction

  // Frame buffer model: registered read, data valid the cycle after pix_rd.
  always @(posedge clk) if (pix_rd) pix_data <= fb_word(pix_x, pix_y);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       {31'd0, busy},       0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    check({tag, "_led_idx"},    {24'd0, led_idx},    0);
    check({tag, "_pix_x"},      {28'd0, pix_x},      0);
    check({tag, "_pix_y"},      {28'd0, pix_y},      0);
    check({tag, "_pix_rd"},     {31'd0, pix_rd},     0);
    check({tag, "_tx_data"},    {8'd0, tx_data},     0);
    check({tag, "_tx_valid"},   {31'd0, tx_valid},   0);
  endtask

  // Push the 25 words a frame must produce, in chain order with serpentine addresses.
  task automatic expect_frame(input logic [23:0] const_exp);
    exp_t e;
    int row, col;
    xfer_base = xfer_cnt;
    for (int k = 0; k < N; k++) begin
      row    = k / W;
      col    = k % W;
      e.idx  = 8'(k);
      e.y    = 4'(row);
      e.x    = (row % 2 == 1) ? 4'(W - 1 - col) : 4'(col);
      e.data = (fb_mode == 2) ? const_exp : fb_word(e.x, e.y);
      sb_q.push_back(e);
    end
  endtask

  task automatic start_frame(input logic [7:0] b);
    @(negedge clk);
    brightness = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("frame_done_seen", {31'd0, (done_cyc >= 0)}, 1);
  endtask

  task automatic end_frame(input string tag);
    check({tag, "_sb_empty"},   sb_q.size(), 0);
    check({tag, "_xfer_count"}, xfer_cnt - xfer_base, N);
  endtask

  // Monitor / tx_ready driver: one line per transfer mismatch, stall stability checks.
  initial begin
    exp_t        e;
    bit          stall;
    logic [23:0] held;
    stall = 1'b0;
    held = '0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && stall) begin
        check("valid_held",  {31'd0, tx_valid}, 1);
        check("data_stable", {8'd0, tx_data},   {8'd0, held});
      end
      tx_ready = bp_mode ? (($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0) : 1'b1;
      if (!mon_en) begin
        stall = 1'b0;
      end else if (tx_valid && tx_ready) begin
        stall = 1'b0;
        xfer_cnt++;
        last_xfer_cyc = cyc + 1;
        check("sb_has_entry", {31'd0, (sb_q.size() != 0)}, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("word_led_idx", {24'd0, led_idx}, {24'd0, e.idx});
          check("word_pix_x",   {28'd0, pix_x},   {28'd0, e.x});
          check("word_pix_y",   {28'd0, pix_y},   {28'd0, e.y});
          check("word_tx_data", {8'd0, tx_data},  {8'd0, e.data});
        end
      end else begin
        stall = tx_valid;
        held = tx_data;
      end
      if (mon_en && frame_done) done_cnt++;
    end
  end

  initial begin
    #(900000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, base_done, rise_edge;
    bit found;

    vecs[0] = '{bright: 8'd255, pix: 24'h123456, exp: 24'h123456};
    vecs[1] = '{bright: 8'd127, pix: 24'hFF8001, exp: 24'h7F4000};
    vecs[2] = '{bright: 8'd0,   pix: 24'hFFFFFF, exp: 24'h000000};
    vecs[3] = '{bright: 8'd1,   pix: 24'hFFFFFF, exp: 24'h010101};
    vecs[4] = '{bright: 8'd63,  pix: 24'h80C0FF, exp: 24'h20303F};
    vecs[5] = '{bright: 8'd200, pix: 24'h64FF10, exp: 24'h4EC80C};

    rst = 1'b1;
    start = 1'b0;
    brightness = 8'd0;
    tx_idle = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Frame order, start latency, brightness held for the frame, latch gap.
    fb_mode = 0;
    expect_frame('0);
    @(negedge clk);
    brightness = 8'd255;
    start = 1'b1;
    @(posedge clk); #1;
    check("lat_busy",    {31'd0, busy},   1);
    check("lat_pix_rd",  {31'd0, pix_rd}, 1);
    check("lat_led_idx", {24'd0, led_idx}, 0);
    start = 1'b0;
    @(posedge clk); #1;
    check("lat_load_rd",    {31'd0, pix_rd},   0);
    check("lat_load_valid", {31'd0, tx_valid}, 0);
    @(posedge clk); #1;
    check("lat_send_valid", {31'd0, tx_valid}, 1);
    brightness = 8'd0;
    wait_done(N * 3 + L + 100, d);
    check("order_latch_gap", d - last_xfer_cyc, L + 1);
    check("done_busy_low", {31'd0, busy}, 0);
    end_frame("order");

    // Scaling table.
    for (int v = 0; v < 6; v++) begin
      fb_mode = 2;
      fb_const = vecs[v].pix;
      expect_frame(vecs[v].exp);
      start_frame(vecs[v].bright);
      wait_done(N * 3 + L + 100, d);
      end_frame("scale");
    end

    // Backpressure: tx_ready high 30% of cycles.
    fb_mode = 1;
    bp_mode = 1'b1;
    expect_frame('0);
    start_frame(8'd255);
    wait_done(N * 40 + L + 100, d);
    end_frame("bp");
    bp_mode = 1'b0;

    // Start pulses while busy are ignored.
    fb_mode = 0;
    base_done = done_cnt;
    expect_frame('0);
    fork
      begin
        start_frame(8'd255);
        wait_done(N * 3 + L + 100, d);
      end
      begin
        repeat (12) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (1500) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
      end
    join
    end_frame("busy_start");
    repeat (40) @(negedge clk);
    check("no_queued_busy",  {31'd0, busy}, 0);
    check("no_queued_xfer",  xfer_cnt - xfer_base, N);
    check("single_done",     done_cnt - base_done, 1);

    // Start coincident with frame_done.
    expect_frame('0);
    start_frame(8'd255);
    wait_done(N * 3 + L + 100, d);
    end_frame("coinc_a");
    expect_frame('0);
    start = 1'b1;
    @(posedge clk); #1;
    check("coinc_busy",   {31'd0, busy},   1);
    check("coinc_pix_rd", {31'd0, pix_rd}, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(N * 3 + L + 100, d);
    end_frame("coinc_b");

    // Reset mid-frame at led_idx 12 in SEND, then a clean restart.
    mon_en = 1'b0;
    start_frame(8'd255);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_valid && led_idx == 8'd12) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_point_found", {31'd0, found}, 1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    mon_en = 1'b1;
    expect_frame('0);
    start_frame(8'd255);
    wait_done(N * 3 + L + 100, d);
    end_frame("restart");

    // Drain: tx_idle low for 500 cycles after the last transfer.
    tx_idle = 1'b0;
    expect_frame('0);
    start_frame(8'd255);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (xfer_cnt - xfer_base == N) break;
    end
    base_done = done_cnt;
    repeat (500) @(negedge clk);
    check("drain_no_done", done_cnt - base_done, 0);
    check("drain_busy",    {31'd0, busy}, 1);
    tx_idle = 1'b1;
    rise_edge = cyc + 1;
    wait_done(L + 100, d);
    check("drain_gap", d - rise_edge, L);
    end_frame("drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
